// File: rtl/my_arb4way16.sv
// Round-robin 4-way arbiter with a one-entry valid/ready output register.
// Optional per-channel grant counters on the gcnt port when MY_ARB_STATS_EN is defined.
module my_arb4way16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       ack,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MY_ARB_STATS_EN
  ,
  output logic [4*CNT_W-1:0] gcnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       ack_q, ack_d;

  logic             free;
  logic             gnt_found;
  logic [1:0]       gnt_idx;
  logic [1:0]       cand;
  logic [WIDTH-1:0] gnt_data;

  // Scan ptr+1, ptr+2, ptr+3, ptr; the 2-bit add provides the 3->0 wrap.
  always_comb begin
    free      = (state_q == EMPTY) || out_ready;
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    cand      = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!gnt_found && req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    case (gnt_idx)
      2'd0:    gnt_data = a;
      2'd1:    gnt_data = b;
      2'd2:    gnt_data = c;
      default: gnt_data = d;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    out_d   = out_q;
    ack_d   = '0;
    if (free) begin
      if (gnt_found) begin
        state_d = FULL;
        ptr_d   = gnt_idx;
        sel_d   = gnt_idx;
        out_d   = gnt_data;
        ack_d   = 4'b0001 << gnt_idx;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= 2'd3;
      sel_q   <= '0;
      out_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      ack_q   <= ack_d;
    end
  end

  assign ack       = ack_q;
  assign sel       = sel_q;
  assign out       = out_q;
  assign out_valid = (state_q == FULL);

`ifdef MY_ARB_STATS_EN
  logic [CNT_W-1:0] gcnt_q [4];
  logic [CNT_W-1:0] gcnt_d [4];

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      gcnt_d[i] = gcnt_q[i];
      if (free && gnt_found && (gnt_idx == 2'(i)) && (gcnt_q[i] != '1))
        gcnt_d[i] = gcnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) gcnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) gcnt_q[i] <= gcnt_d[i];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_gcnt
    assign gcnt[g*CNT_W +: CNT_W] = gcnt_q[g];
  end
`endif

endmodule

// File: tb/tb_my_arb4way16.sv
// Bench for my_arb4way16: directed vector table, hand sequences, and a randomized
// run against a rule-level reference model (gcnt checked when MY_ARB_STATS_EN is defined).
module tb_my_arb4way16;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req;
  logic [WIDTH-1:0] a, b, c, d;
  logic [3:0]       ack;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
`ifdef MY_ARB_STATS_EN
  logic [4*CNT_W-1:0] gcnt;
`endif

  my_arb4way16 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .ack       (ack),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MY_ARB_STATS_EN
    ,
    .gcnt      (gcnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic        rdy;
    logic        v;
    logic [1:0]  sel;
    logic [15:0] out;
    logic [3:0]  ack;
  } vec_t;

  vec_t tbl[10];

  // Drive one cycle of inputs, wait past the edge, compare all outputs.
  task automatic apply(input string name, input logic r, input logic [3:0] rq, input logic rd,
                       input logic ev, input logic [1:0] es, input logic [15:0] eo,
                       input logic [3:0] ea);
    rst_n = r; req = rq; out_ready = rd;
    @(posedge clk); #1;
    check(name, {39'd0, out_valid, sel, out, ack}, {39'd0, ev, es, eo, ea});
  endtask

  // Reference model: arbitration rules stated directly with integers.
  int          m_ptr;
  bit          m_v;
  logic [15:0] m_out;
  int          m_sel;
  logic [3:0]  m_ack;
  int          m_cnt[4];

  task automatic model_step();
    logic [15:0] dat[4];
    bit free;
    int pick;
    dat[0] = a; dat[1] = b; dat[2] = c; dat[3] = d;
    if (!rst_n) begin
      m_v = 0; m_out = 0; m_sel = 0; m_ack = 0; m_ptr = 3;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      return;
    end
    free = !m_v || out_ready;
    m_ack = 0;
    if (!free) return;
    pick = -1;
    for (int k = 1; k <= 4; k++)
      if (pick < 0 && req[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
    if (pick < 0) begin
      m_v = 0;
    end else begin
      m_v = 1; m_out = dat[pick]; m_sel = pick; m_ptr = pick;
      m_ack = 4'(1 << pick);
      if (m_cnt[pick] < (1 << CNT_W) - 1) m_cnt[pick]++;
    end
  endtask

  initial begin
    a = 16'h5555; b = 16'hAAAA; c = 16'h00FF; d = 16'hFF00;
    rst_n = 1'b0; req = 4'hF; out_ready = 1'b1;

    tbl[0] = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 16'h0000, 4'b0000};
    tbl[1] = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 16'h0000, 4'b0000};
    tbl[2] = '{1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 16'h5555, 4'b0001};
    tbl[3] = '{1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 16'h5555, 4'b0001};
    tbl[4] = '{1'b1, 4'b1111, 1'b1, 1'b1, 2'd1, 16'hAAAA, 4'b0010};
    tbl[5] = '{1'b1, 4'b1111, 1'b1, 1'b1, 2'd2, 16'h00FF, 4'b0100};
    tbl[6] = '{1'b1, 4'b1111, 1'b1, 1'b1, 2'd3, 16'hFF00, 4'b1000};
    tbl[7] = '{1'b1, 4'b1111, 1'b1, 1'b1, 2'd0, 16'h5555, 4'b0001};
    tbl[8] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h5555, 4'b0000};
    tbl[9] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 16'h5555, 4'b0000};

    for (int i = 0; i < 10; i++)
      apply($sformatf("tbl%0d", i), tbl[i].rst_n, tbl[i].req, tbl[i].rdy,
            tbl[i].v, tbl[i].sel, tbl[i].out, tbl[i].ack);

    // Stall: held word and sel survive while out_ready is low, then drain+grant.
    apply("stall_grant", 1'b1, 4'b0110, 1'b1, 1'b1, 2'd1, 16'hAAAA, 4'b0010);
    for (int i = 0; i < 5; i++)
      apply($sformatf("stall_hold%0d", i), 1'b1, 4'b0110, 1'b0, 1'b1, 2'd1, 16'hAAAA, 4'b0000);
    apply("stall_release", 1'b1, 4'b0110, 1'b1, 1'b1, 2'd2, 16'h00FF, 4'b0100);

    // Reset mid-stall drops the word and restores ch0 priority.
    apply("rst_stall", 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0000, 4'b0000);
    apply("post_rst_grant", 1'b1, 4'b1001, 1'b1, 1'b1, 2'd0, 16'h5555, 4'b0001);
    apply("post_rst_next", 1'b1, 4'b1001, 1'b1, 1'b1, 2'd3, 16'hFF00, 4'b1000);

    // Randomized run against the model, with occasional resets.
    rst_n = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      model_step();
      @(posedge clk); #1;
      check($sformatf("rand%0d", n), {39'd0, out_valid, sel, out, ack},
            {39'd0, m_v, 2'(m_sel), m_out, m_ack});
`ifdef MY_ARB_STATS_EN
      check($sformatf("rand_gcnt%0d", n), 64'(gcnt),
            64'({8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])}));
`endif
      rst_n     = (n < 1) ? 1'b0 : ($urandom_range(99) >= 3);
      req       = 4'($urandom);
      out_ready = ($urandom_range(3) != 0);
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
    end

`ifdef MY_ARB_STATS_EN
    // Single requester for 300 cycles: its counter saturates, others stay zero.
    rst_n = 1'b0; req = 4'b0100; out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
    end
    check("gcnt_sat", 64'(gcnt), 64'({8'd0, 8'd255, 8'd0, 8'd0}));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
